// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings and defaults for the pipeline stall/bubble controller.
// Tnew/Tuse are small cycle counts; Tuse of 3 marks an operand that is not read.
package hazard_ctrl_pkg;

    localparam logic [1:0] TNEW_0    = 2'd0;
    localparam logic [1:0] TNEW_1    = 2'd1;
    localparam logic [1:0] TNEW_2    = 2'd2;
    localparam logic [1:0] TUSE_0    = 2'd0;
    localparam logic [1:0] TUSE_1    = 2'd1;
    localparam logic [1:0] TUSE_2    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Tnew one stage later; saturates at zero so a finished result stays ready.
    function automatic logic [1:0] tnew_advance(input logic [1:0] tnew);
        return (tnew == TNEW_0) ? TNEW_0 : tnew - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_sched.sv
// Mult/div scheduler: start pulse while the md instruction sits in E,
// then a down-counter that keeps the unit busy for the operation latency.
module hazard_ctrl_md_sched
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CW      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_E,
    input  logic divsel_E,
    output logic md_start,
    output logic md_busy
);

    logic [CW-1:0] cnt;

    assign md_start = md_E;
    assign md_busy  = (cnt != '0);

    // A start always reloads, even if the unit is still counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (md_start) begin
            cnt <= divsel_E ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/bubble controller for the five-stage pipeline: Tuse/Tnew data-hazard
// detection against a private E/M shadow, plus mult/div busy interlock.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CW      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs,
    input  logic [1:0] tuse_rt,
    input  logic [4:0] dest_D,
    input  logic [1:0] tnew_D,
    input  logic       md_D,
    input  logic       div_D,
    input  logic       hilo_D,
    output logic       stall,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_clr,
    output logic       md_start,
    output logic       md_busy
);

    logic [4:0] dest_E, dest_M;
    logic [1:0] tnew_E, tnew_M;
    logic       md_E, divsel_E;
    logic       stall_rs, stall_rt, md_stall;

    // A stalled D instruction does not advance; E receives a bubble instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dest_E   <= REG_ZERO;
            tnew_E   <= TNEW_0;
            md_E     <= 1'b0;
            divsel_E <= 1'b0;
            dest_M   <= REG_ZERO;
            tnew_M   <= TNEW_0;
        end else begin
            if (stall) begin
                dest_E   <= REG_ZERO;
                tnew_E   <= TNEW_0;
                md_E     <= 1'b0;
                divsel_E <= 1'b0;
            end else begin
                dest_E   <= dest_D;
                tnew_E   <= tnew_D;
                md_E     <= md_D;
                divsel_E <= div_D;
            end
            dest_M <= dest_E;
            tnew_M <= tnew_advance(tnew_E);
        end
    end

    // Stall only when the producer's result arrives later than the consumer needs it.
    always_comb begin
        stall_rs = (rs_D != REG_ZERO) &&
                   (((rs_D == dest_E) && (tnew_E > tuse_rs)) ||
                    ((rs_D == dest_M) && (tnew_M > tuse_rs)));
        stall_rt = (rt_D != REG_ZERO) &&
                   (((rt_D == dest_E) && (tnew_E > tuse_rt)) ||
                    ((rt_D == dest_M) && (tnew_M > tuse_rt)));
    end

    hazard_ctrl_md_sched #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CW      (CW)
    ) u_md_sched (
        .clk      (clk),
        .reset    (reset),
        .md_E     (md_E),
        .divsel_E (divsel_E),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    assign md_stall = hilo_D & (md_start | md_busy);
    assign stall    = stall_rs | stall_rt | md_stall;
    assign pc_en    = ~stall;
    assign ifid_en  = ~stall;
    assign idex_clr = stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each cycle's D-stage vector goes with a
// hand-computed expected output word; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs_D, rt_D, dest_D;
    logic [1:0] tuse_rs, tuse_rt, tnew_D;
    logic       md_D, div_D, hilo_D;
    logic       stall, pc_en, ifid_en, idex_clr, md_start, md_busy;

    // Expected word: {stall, pc_en, ifid_en, idex_clr, md_start, md_busy}
    localparam int W = 6;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    hazard_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .rs_D     (rs_D),
        .rt_D     (rt_D),
        .tuse_rs  (tuse_rs),
        .tuse_rt  (tuse_rt),
        .dest_D   (dest_D),
        .tnew_D   (tnew_D),
        .md_D     (md_D),
        .div_D    (div_D),
        .hilo_D   (hilo_D),
        .stall    (stall),
        .pc_en    (pc_en),
        .ifid_en  (ifid_en),
        .idex_clr (idex_clr),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver ----------------
    // One call = one cycle: wait for the edge, apply the D-stage instruction,
    // queue the outputs expected for that same cycle.
    task automatic step(input logic rst,
                        input logic [4:0] rs, input logic [1:0] trs,
                        input logic [4:0] rt, input logic [1:0] trt,
                        input logic [4:0] dst, input logic [1:0] tn,
                        input logic md, input logic dv, input logic hl,
                        input logic e_stall, input logic e_start, input logic e_busy,
                        input string nm);
        @(posedge clk);
        #1;
        reset   = rst;
        rs_D    = rs;
        tuse_rs = trs;
        rt_D    = rt;
        tuse_rt = trt;
        dest_D  = dst;
        tnew_D  = tn;
        md_D    = md;
        div_D   = dv;
        hilo_D  = hl;
        exp_q.push_back({e_stall, ~e_stall, ~e_stall, e_stall, e_start, e_busy});
        name_q.push_back(nm);
    endtask

    task automatic nop(input logic e_start, input logic e_busy, input string nm);
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0,
             1'b0, e_start, e_busy, nm);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] exp_w, act_w;
            string        nm;
            exp_w = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_w = {stall, pc_en, ifid_en, idex_clr, md_start, md_busy};
            checks++;
            if (act_w !== exp_w) begin
                errors++;
                $display("FAIL %s: got %b expected %b (stall,pc_en,ifid_en,idex_clr,md_start,md_busy)",
                         nm, act_w, exp_w);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        rs_D = 5'd0; rt_D = 5'd0; dest_D = 5'd0;
        tuse_rs = 2'd3; tuse_rt = 2'd3; tnew_D = 2'd0;
        md_D = 1'b0; div_D = 1'b0; hilo_D = 1'b0;

        step(1'b1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, "in_reset");
        nop(0, 0, "after_reset");

        // Load-use: lw $3 then add using $3 -> exactly one bubble
        step(0, 0, 3, 0, 3, 3, 2, 0, 0, 0, 0, 0, 0, "lw3");
        step(0, 3, 1, 0, 3, 4, 1, 0, 0, 0, 1, 0, 0, "loaduse_stall");
        step(0, 3, 1, 0, 3, 4, 1, 0, 0, 0, 0, 0, 0, "loaduse_release");
        nop(0, 0, "lu_drain1");
        nop(0, 0, "lu_drain2");

        // ALU -> branch: one bubble, then released from M
        step(0, 0, 3, 0, 3, 5, 1, 0, 0, 0, 0, 0, 0, "add5");
        step(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "branch_stall");
        step(0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "branch_release");
        // Register 0 never stalls, even against a pending write to "none"
        step(0, 0, 3, 0, 3, 0, 2, 0, 0, 0, 0, 0, 0, "write_r0");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "r0_vs_E");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "r0_vs_M");
        nop(0, 0, "br_drain");

        // Store data (tuse 2) behind load: no stall; tuse 1: one stall
        step(0, 0, 3, 0, 3, 7, 2, 0, 0, 0, 0, 0, 0, "lw7");
        step(0, 2, 1, 7, 2, 0, 0, 0, 0, 0, 0, 0, 0, "store_tuse2");
        step(0, 0, 3, 0, 3, 8, 2, 0, 0, 0, 0, 0, 0, "lw8");
        step(0, 0, 3, 8, 1, 0, 0, 0, 0, 0, 1, 0, 0, "rt_tuse1_stall");
        step(0, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0, "rt_tuse1_release");
        nop(0, 0, "st_drain");

        // mult then mflo: stall for start cycle plus 5 busy cycles
        step(0, 1, 1, 2, 1, 0, 0, 1, 0, 1, 0, 0, 0, "mult_issue");
        step(0, 0, 3, 0, 3, 9, 1, 0, 0, 1, 1, 1, 0, "mflo_start");
        for (int i = 0; i < 5; i++)
            step(0, 0, 3, 0, 3, 9, 1, 0, 0, 1, 1, 0, 1, $sformatf("mflo_busy%0d", i));
        step(0, 0, 3, 0, 3, 9, 1, 0, 0, 1, 0, 0, 0, "mflo_go");
        nop(0, 0, "mult_drain");

        // div: 10 busy cycles; non-HI/LO traffic flows through
        step(0, 1, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0, 0, "div_issue");
        step(0, 0, 1, 0, 3, 10, 1, 0, 0, 0, 0, 1, 0, "div_start");
        for (int i = 0; i < 10; i++)
            nop(0, 1, $sformatf("div_busy%0d", i));
        nop(0, 0, "div_done");

        // Reset mid-count (cnt=7) clears busy and shadow at once
        step(0, 1, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0, 0, "div2_issue");
        nop(1, 0, "div2_start");
        nop(0, 1, "div2_cnt10");
        nop(0, 1, "div2_cnt9");
        step(0, 0, 3, 0, 3, 3, 2, 0, 0, 0, 0, 0, 1, "lw3_cnt8");
        step(1, 3, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, "reset_at_cnt7");
        step(0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, "post_reset_shadow");
        step(0, 3, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, "post_reset_edge1");

        // Forced back-to-back mult (hilo_D low): second start reloads counter
        step(0, 0, 3, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, "mult_a");
        step(0, 0, 3, 0, 3, 0, 0, 1, 0, 0, 0, 1, 0, "mult_b_start_a");
        nop(1, 1, "start_b_busy");
        for (int i = 0; i < 5; i++)
            nop(0, 1, $sformatf("reload_busy%0d", i));
        nop(0, 0, "reload_done");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Stall/bubble controller for the five-stage MIPS pipeline.
- Keeps its own shadow of the destination register and Tnew for the E and M stages. Compares the D-stage instruction's source registers and Tuse against that shadow, then holds PC and IF/ID and inserts a bubble into ID/EX when a forward cannot yet supply the operand.
- Also schedules the multi-cycle mult/div unit: issues its start pulse and stalls any D-stage HI/LO or mult/div instruction while the unit is busy.

Parameters:
- MUL_LAT, 5, busy cycles after a mult/multu start.
- DIV_LAT, 10, busy cycles after a div/divu start.
- CW, 4, busy-counter width; must satisfy 2^CW > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous active-high reset.
- rs_D  in  5  rs field of the D-stage instruction.
- rt_D  in  5  rt field of the D-stage instruction.
- tuse_rs  in  2  cycles until the D instr needs rs (0 branch/jr, 1 ALU, 3 = not used).
- tuse_rt  in  2  same for rt (2 for store data, 3 = not used).
- dest_D  in  5  register the D instr writes (0 = none).
- tnew_D  in  2  cycles after entering E until the result is ready (0 jal/lui-class, 1 ALU, 2 load).
- md_D  in  1  D instr is mult/multu/div/divu.
- div_D  in  1  qualifies md_D: 1 = divide.
- hilo_D  in  1  D instr is md_D, mfhi/mflo or mthi/mtlo.
- stall  out  1  hazard present this cycle.
- pc_en  out  1  PC write enable (= !stall).
- ifid_en  out  1  IF/ID write enable (= !stall).
- idex_clr  out  1  load NOP into ID/EX next edge (= stall).
- md_start  out  1  one-cycle start to the mult/div unit; high while the md instr is in E.
- md_busy  out  1  mult/div unit computing.

Behaviour:
- Shadow state: dest_E, tnew_E, md_E, divsel_E, dest_M, tnew_M, busy counter cnt[CW-1:0].
- Async reset clears all state to 0. Immediately after reset: stall=0, pc_en=1, ifid_en=1, idex_clr=0, md_start=0, md_busy=0.
- On each posedge:
  - If stall=1: E shadow loads a bubble (dest 0, tnew 0, md 0).
  - Otherwise: E shadow loads dest_D, tnew_D, md_D, div_D.
  - M shadow always loads dest_E and tnew_M_next = (tnew_E==0) ? 0 : tnew_E-1 (saturating, never wraps).
- Data stall (combinational):
  - stall_rs = (rs_D!=0) & ((rs_D==dest_E & tnew_E>tuse_rs) | (rs_D==dest_M & tnew_M>tuse_rs)). stall_rt is the same with rt_D and tuse_rt.
  - Tuse=3 never stalls, since Tnew is at most 2.
  - Register 0 never stalls.
  - W stage never stalls: Tnew there is 0 by construction.
- md_start = md_E. Issue therefore happens exactly one cycle after the md instr leaves D un-stalled.
- Counter:
  - If md_start: cnt <= divsel_E ? DIV_LAT : MUL_LAT.
  - Else if cnt!=0: cnt <= cnt-1.
  - md_busy = (cnt!=0).
- md_stall = hilo_D & (md_start | md_busy).
- stall = stall_rs | stall_rt | md_stall.
- Simultaneous events:
  - A data stall and md_stall together give a single stall with the same outputs.
  - A new md_start while busy cannot occur, because md_stall blocks it. If it is forced anyway, md_start wins and the counter reloads.
- Latency: stall is combinational and same-cycle. Shadow updates take effect one cycle later.
- Reset asserted mid-count: cnt clears at once, md_busy drops asynchronously, and the shadow pipeline empties.

Decomposition:
- Shared package holds:
  - Tnew/Tuse encodings: TNEW_0/1/2, TUSE_0/1/2, TUSE_NONE=3.
  - MUL_LAT/DIV_LAT defaults.
  - Register-zero constant.
- One natural sub-module: md_sched (busy counter, md_start, md_busy). The comparator logic stays in hazard_ctrl.

Test Plan:
- Load-use: lw $3 (dest 3, tnew 2) enters E, then D = add using rs=3, tuse 1 → stall=1 for 1 cycle. Next cycle tnew_M=1 ≤1 → stall=0, and idex_clr pulsed exactly once.
- ALU→branch: add $5 in E (tnew 1), beq rs=5 tuse 0 → stall 1 cycle. Then M tnew 0 → released. The same case with rs=0 → never stalls.
- mult issue then mflo: mult leaves D, md_start high 1 cycle, md_busy high 5 cycles. mflo in D → stall for 6 cycles total (start cycle + 5), then proceeds.
- div: md_busy high exactly 10 cycles after md_start. Non-HI/LO instrs in D during busy → no stall.
- Reset when cnt=7 → md_busy=0, stall=0 and pc_en=1 immediately. All shadow regs read 0 on the first edge after reset releases.
- Store with tuse_rt 2 behind lw dest=rt (tnew 2) → no stall (2>2 false). Same pair with tuse_rt 1 → 1-cycle stall.
